sound_sequencer: RTL and testbench

- Event-driven tone sequencer for the Pong game audio path.
- Replaces fixed single-bit tone selection with multi-note sequences per game event.
- Adds per-note durations, inter-note gaps, priority/pre-emption between events, mute, and a busy flag.
- Drives the board speaker pin directly. Runs on the 25 MHz pixel clock domain.

---
 rtl/sound_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_sound_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sound_sequencer.sv
// Event-driven multi-note tone sequencer for the Pong speaker (hit/point/lose, priority pre-emption, mute).
// Optional win jingle after every WIN_POINTS point edges is enabled by defining SOUND_WIN_JINGLE_EN.
module sound_sequencer #(
    parameter int CLK_HZ    = 25000000,
    parameter int TICK_HZ   = 1000,
    parameter int PER_W     = 17,
    parameter int DUR_W     = 9,
    parameter int GAP_TICKS = 10,
`ifdef SOUND_WIN_JINGLE_EN
    parameter int WIN_POINTS = 5,
`endif
    // Divides every ROM half-period; 1 gives the nominal pitches at 25 MHz.
    parameter int HALF_DIV  = 1
) (
    input  logic       clk25,
    input  logic       rst,
    input  logic       hit,
    input  logic       point,
    input  logic       lose,
    input  logic       mute,
    output logic       speaker,
    output logic       busy,
`ifdef SOUND_WIN_JINGLE_EN
    output logic [2:0] cur_evt
`else
    output logic [1:0] cur_evt
`endif
);

`ifdef SOUND_WIN_JINGLE_EN
    localparam int EVT_W = 3;
`else
    localparam int EVT_W = 2;
`endif
    localparam int TDIV  = CLK_HZ / TICK_HZ;
    localparam int PRE_W = $clog2(TDIV);

    localparam int H_HIT = 25000 / HALF_DIV;
    localparam int H_PT1 = 12500 / HALF_DIV;
    localparam int H_PT2 = 6250 / HALF_DIV;
    localparam int H_LS1 = 31250 / HALF_DIV;
    localparam int H_LS2 = 41667 / HALF_DIV;
    localparam int H_LS3 = 62500 / HALF_DIV;

    typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

    state_t             state_reg, state_next;
    logic [EVT_W-1:0]   evt_reg, evt_next, new_evt;
    logic [1:0]         note_reg, note_next;
    logic [PER_W-1:0]   phase_reg, phase_next;
    logic [PRE_W-1:0]   pre_reg, pre_next;
    logic [DUR_W-1:0]   tick_reg, tick_next;
    logic               tone_reg, tone_next;
    logic [2:0]         in_reg, prev_reg;
    logic [2:0]         edge_w;
    logic [PER_W-1:0]   rom_half;
    logic [DUR_W-1:0]   rom_dur;
    logic               rom_last;

    // Bit order everywhere: {lose, point, hit}.
    assign edge_w = in_reg & ~prev_reg;

    always_ff @(posedge clk25) begin
        if (rst) begin
            in_reg   <= '0;
            prev_reg <= '0;
        end else begin
            in_reg   <= {lose, point, hit};
            prev_reg <= in_reg;
        end
    end

`ifdef SOUND_WIN_JINGLE_EN
    localparam int WC_W  = $clog2(WIN_POINTS + 1);
    localparam int H_WN2 = 9375 / HALF_DIV;
    localparam int H_WN3 = 7813 / HALF_DIV;

    logic [WC_W-1:0] win_cnt_reg;
    logic            win_fire;

    assign win_fire = edge_w[1] && (win_cnt_reg == WC_W'(WIN_POINTS - 1));

    // Counts every point edge, including ones later dropped by priority.
    always_ff @(posedge clk25) begin
        if (rst)
            win_cnt_reg <= '0;
        else if (edge_w[1])
            win_cnt_reg <= win_fire ? '0 : win_cnt_reg + WC_W'(1);
    end
`endif

    // Event codes double as priority: a larger code wins.
    always_comb begin
        new_evt = '0;
        if (edge_w[2])
            new_evt = EVT_W'(3);
        else if (edge_w[1])
            new_evt = EVT_W'(2);
        else if (edge_w[0])
            new_evt = EVT_W'(1);
`ifdef SOUND_WIN_JINGLE_EN
        if (win_fire)
            new_evt = EVT_W'(4);
`endif
    end

    always_comb begin
        rom_half = PER_W'(H_HIT);
        rom_dur  = DUR_W'(30);
        rom_last = 1'b1;
        case (evt_reg)
            EVT_W'(2): begin
                rom_dur  = DUR_W'(80);
                rom_half = (note_reg == 2'd0) ? PER_W'(H_PT1) : PER_W'(H_PT2);
                rom_last = (note_reg != 2'd0);
            end
            EVT_W'(3): begin
                case (note_reg)
                    2'd0:    begin rom_half = PER_W'(H_LS1); rom_dur = DUR_W'(150); rom_last = 1'b0; end
                    2'd1:    begin rom_half = PER_W'(H_LS2); rom_dur = DUR_W'(150); rom_last = 1'b0; end
                    default: begin rom_half = PER_W'(H_LS3); rom_dur = DUR_W'(300); end
                endcase
            end
`ifdef SOUND_WIN_JINGLE_EN
            EVT_W'(4): begin
                case (note_reg)
                    2'd0:    begin rom_half = PER_W'(H_PT1); rom_dur = DUR_W'(60); rom_last = 1'b0; end
                    2'd1:    begin rom_half = PER_W'(H_WN2); rom_dur = DUR_W'(60); rom_last = 1'b0; end
                    2'd2:    begin rom_half = PER_W'(H_WN3); rom_dur = DUR_W'(60); rom_last = 1'b0; end
                    default: begin rom_half = PER_W'(H_PT2); rom_dur = DUR_W'(200); end
                endcase
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        evt_next   = evt_reg;
        note_next  = note_reg;
        phase_next = phase_reg;
        pre_next   = pre_reg;
        tick_next  = tick_reg;
        tone_next  = tone_reg;
        // evt_reg is 0 in IDLE, so starting and pre-empting share one path.
        if (new_evt > evt_reg) begin
            state_next = TONE;
            evt_next   = new_evt;
            note_next  = 2'd0;
            phase_next = '0;
            pre_next   = '0;
            tick_next  = '0;
            tone_next  = 1'b0;
        end else begin
            case (state_reg)
                TONE: begin
                    if (phase_reg == rom_half - PER_W'(1)) begin
                        phase_next = '0;
                        tone_next  = ~tone_reg;
                    end else begin
                        phase_next = phase_reg + PER_W'(1);
                    end
                    if (pre_reg == PRE_W'(TDIV - 1)) begin
                        pre_next = '0;
                        if (tick_reg == rom_dur - DUR_W'(1)) begin
                            phase_next = '0;
                            tick_next  = '0;
                            tone_next  = 1'b0;
                            if (rom_last) begin
                                state_next = IDLE;
                                evt_next   = '0;
                                note_next  = 2'd0;
                            end else begin
                                state_next = GAP;
                                note_next  = note_reg + 2'd1;
                            end
                        end else begin
                            tick_next = tick_reg + DUR_W'(1);
                        end
                    end else begin
                        pre_next = pre_reg + PRE_W'(1);
                    end
                end
                GAP: begin
                    if (pre_reg == PRE_W'(TDIV - 1)) begin
                        pre_next = '0;
                        if (tick_reg == DUR_W'(GAP_TICKS - 1)) begin
                            state_next = TONE;
                            tick_next  = '0;
                            phase_next = '0;
                            tone_next  = 1'b0;
                        end else begin
                            tick_next = tick_reg + DUR_W'(1);
                        end
                    end else begin
                        pre_next = pre_reg + PRE_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk25) begin
        if (rst) begin
            state_reg <= IDLE;
            evt_reg   <= '0;
            note_reg  <= 2'd0;
            phase_reg <= '0;
            pre_reg   <= '0;
            tick_reg  <= '0;
            tone_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            evt_reg   <= evt_next;
            note_reg  <= note_next;
            phase_reg <= phase_next;
            pre_reg   <= pre_next;
            tick_reg  <= tick_next;
            tone_reg  <= tone_next;
        end
    end

    assign busy    = (state_reg != IDLE);
    assign cur_evt = evt_reg;
    assign speaker = tone_reg & ~mute & (state_reg == TONE);

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed bench for sound_sequencer, scaled to TDIV = 100 cycles and half-periods divided by 100.
// Pitches: hit 250, point 125/62, lose 312/416/625; durations hit 3000, point 8000+8000 with a 1000 gap.
module tb_sound_sequencer;
    logic clk25 = 1'b0;
    logic rst, hit, point, lose, mute;
    logic speaker, busy;
`ifdef SOUND_WIN_JINGLE_EN
    logic [2:0] cur_evt;
`else
    logic [1:0] cur_evt;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk25 = ~clk25;

    sound_sequencer #(
        .CLK_HZ(100000),
        .TICK_HZ(1000),
`ifdef SOUND_WIN_JINGLE_EN
        .WIN_POINTS(3),
`endif
        .HALF_DIV(100)
    ) dut (
        .clk25(clk25), .rst(rst), .hit(hit), .point(point), .lose(lose),
        .mute(mute), .speaker(speaker), .busy(busy), .cur_evt(cur_evt)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk25);
    endtask

    // Pulses {lose,point,hit} for one cycle; returns on the first cycle of the new sequence.
    task automatic pulse(input logic [2:0] m);
        {lose, point, hit} = m;
        @(negedge clk25);
        {lose, point, hit} = 3'b000;
        @(negedge clk25);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(1);
    endtask

    task automatic run_count(input int n, output int changes, output int first, output int busy_low);
        logic p;
        p = speaker; changes = 0; first = -1; busy_low = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk25);
            if (speaker !== p) begin
                changes++;
                if (first < 0) first = i;
            end
            p = speaker;
            if (busy !== 1'b1) busy_low++;
        end
    endtask

    task automatic test_reset();
        int ch, fi, bl;
        step(3);
        vectors++; if (speaker !== 1'b0) begin miscompares++; $display("FAIL rst_speaker: got %b expected 0", speaker); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected 0", busy); end
        vectors++; if (cur_evt !== 0) begin miscompares++; $display("FAIL rst_evt: got %0d expected 0", cur_evt); end
        rst = 1'b0;
        step(1);
        pulse(3'b100);
        vectors++; if (cur_evt !== 3) begin miscompares++; $display("FAIL rst_lose_start: got %0d expected 3", cur_evt); end
        run_count(400, ch, fi, bl);
        vectors++; if (fi !== 312) begin miscompares++; $display("FAIL rst_lose_first_toggle: got %0d expected 312", fi); end
        vectors++; if (speaker !== 1'b1) begin miscompares++; $display("FAIL rst_lose_speaker: got %b expected 1", speaker); end
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step(1);
            vectors++;
            if ({speaker, busy, cur_evt} !== '0) begin
                miscompares++;
                $display("FAIL rst_abort_c%0d: got speaker=%b busy=%b evt=%0d expected all 0", c, speaker, busy, cur_evt);
            end
        end
        rst = 1'b0;
        step(1);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_release_busy: got %b expected 0", busy); end
        $display("test_reset done");
    endtask

    task automatic test_hit();
        int ch, fi, bl;
        pulse(3'b001);
        vectors++; if ({busy, speaker} !== 2'b10 || cur_evt !== 1) begin miscompares++; $display("FAIL hit_start: got busy=%b spk=%b evt=%0d expected 1 0 1", busy, speaker, cur_evt); end
        run_count(2999, ch, fi, bl);
        vectors++; if (ch !== 11 || fi !== 250) begin miscompares++; $display("FAIL hit_toggles: got %0d first %0d expected 11 first 250", ch, fi); end
        vectors++; if (bl !== 0) begin miscompares++; $display("FAIL hit_busy_hold: got %0d low cycles expected 0", bl); end
        step(1);
        vectors++; if ({busy, speaker} !== 2'b00 || cur_evt !== 0) begin miscompares++; $display("FAIL hit_end: got busy=%b spk=%b evt=%0d expected 0 0 0", busy, speaker, cur_evt); end
        $display("test_hit done");
    endtask

    task automatic test_point();
        int ch, fi, bl;
        pulse(3'b010);
        vectors++; if (cur_evt !== 2) begin miscompares++; $display("FAIL pt_start: got %0d expected 2", cur_evt); end
        run_count(7999, ch, fi, bl);
        vectors++; if (ch !== 63 || fi !== 125) begin miscompares++; $display("FAIL pt_note1: got %0d first %0d expected 63 first 125", ch, fi); end
        run_count(1000, ch, fi, bl);
        vectors++; if (ch !== 1 || fi !== 1) begin miscompares++; $display("FAIL pt_gap: got %0d first %0d expected 1 first 1", ch, fi); end
        vectors++; if (bl !== 0) begin miscompares++; $display("FAIL pt_gap_busy: got %0d low cycles expected 0", bl); end
        run_count(8000, ch, fi, bl);
        vectors++; if (ch !== 129 || fi !== 63) begin miscompares++; $display("FAIL pt_note2: got %0d first %0d expected 129 first 63", ch, fi); end
        vectors++; if (bl !== 0) begin miscompares++; $display("FAIL pt_note2_busy: got %0d low cycles expected 0", bl); end
        step(1);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL pt_end: got %b expected 0", busy); end
        $display("test_point done");
    endtask

    task automatic test_priority();
        int ch, fi, bl;
        pulse(3'b011);
        vectors++; if (cur_evt !== 2) begin miscompares++; $display("FAIL pri_simul: got %0d expected 2", cur_evt); end
        do_reset();
        pulse(3'b010);
        run_count(100, ch, fi, bl);
        pulse(3'b001);
        run_count(98, ch, fi, bl);
        vectors++; if (ch !== 1 || fi !== 23 || cur_evt !== 2) begin miscompares++; $display("FAIL pri_hit_drop: got %0d first %0d evt %0d expected 1 first 23 evt 2", ch, fi, cur_evt); end
        run_count(7799, ch, fi, bl);
        vectors++; if (ch !== 62 || fi !== 50) begin miscompares++; $display("FAIL pri_pt_timing: got %0d first %0d expected 62 first 50", ch, fi); end
        run_count(1000, ch, fi, bl);
        run_count(101, ch, fi, bl);
        vectors++; if (fi !== 63) begin miscompares++; $display("FAIL pri_note2_toggle: got %0d expected 63", fi); end
        pulse(3'b100);
        vectors++; if ({busy, speaker} !== 2'b10 || cur_evt !== 3) begin miscompares++; $display("FAIL pri_lose_preempt: got busy=%b spk=%b evt=%0d expected 1 0 3", busy, speaker, cur_evt); end
        run_count(312, ch, fi, bl);
        vectors++; if (ch !== 1 || fi !== 312) begin miscompares++; $display("FAIL pri_lose_toggle: got %0d first %0d expected 1 first 312", ch, fi); end
        pulse(3'b010);
        vectors++; if (cur_evt !== 3) begin miscompares++; $display("FAIL pri_lower_drop: got %0d expected 3", cur_evt); end
        do_reset();
        $display("test_priority done");
    endtask

    task automatic test_mute();
        int ch, fi, bl;
        mute = 1'b1;
        pulse(3'b001);
        run_count(2999, ch, fi, bl);
        vectors++; if (ch !== 0 || speaker !== 1'b0) begin miscompares++; $display("FAIL mute_silent: got %0d changes spk=%b expected 0 0", ch, speaker); end
        vectors++; if (bl !== 0 || busy !== 1'b1) begin miscompares++; $display("FAIL mute_busy: got %0d low, busy=%b expected 0 low, 1", bl, busy); end
        step(1);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mute_end: got %b expected 0", busy); end
        mute = 1'b0;
        $display("test_mute done");
    endtask

`ifdef SOUND_WIN_JINGLE_EN
    task automatic test_win();
        int ch, fi, bl, w;
        do_reset();
        pulse(3'b010);
        step(10);
        pulse(3'b010);
        vectors++; if (cur_evt !== 2) begin miscompares++; $display("FAIL win_second_point: got %0d expected 2", cur_evt); end
        step(10);
        pulse(3'b010);
        vectors++; if (cur_evt !== 4 || speaker !== 1'b0) begin miscompares++; $display("FAIL win_start: got evt=%0d spk=%b expected 4 0", cur_evt, speaker); end
        run_count(125, ch, fi, bl);
        vectors++; if (fi !== 125) begin miscompares++; $display("FAIL win_first_toggle: got %0d expected 125", fi); end
        w = 0;
        while (busy && w < 45000) begin step(1); w++; end
        vectors++; if (w !== 40875) begin miscompares++; $display("FAIL win_length: got %0d expected 40875", w); end
        pulse(3'b010);
        vectors++; if (cur_evt !== 2) begin miscompares++; $display("FAIL win_fourth_point: got %0d expected 2", cur_evt); end
        do_reset();
        $display("test_win done");
    endtask
`endif

    initial begin
        rst = 1'b1; hit = 1'b0; point = 1'b0; lose = 1'b0; mute = 1'b0;
        test_reset();
        test_hit();
        test_point();
        test_priority();
        test_mute();
`ifdef SOUND_WIN_JINGLE_EN
        test_win();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation still running at time limit, expected completion");
        $fatal(1, "time limit");
    end
endmodule
